// File: rtl/input_conditioner.sv
// Four-button conditioner: 2-flop sync, per-button debounce, fixed-priority arbitration, valid/ready move requests.
// Define AUTO_REPEAT_EN to re-issue the held direction after REPEAT_DELAY and then every REPEAT_PERIOD cycles.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic [3:0] held
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
          REPEAT_DELAY > 2**26 || REPEAT_PERIOD > 2**26) begin : g_bad_cfg
         $error("input_conditioner: parameter out of range");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, REQ, DELAY, REPEAT, RELEASE} state_t;

   logic [3:0] raw;
   logic [3:0] held_w;
   logic [3:0] held_prev_q;
   logic [1:0] arb_dir;
   state_t     state_q;
   logic       move_valid_q;
   logic [1:0] move_dir_q;

   assign raw = {btn_right, btn_left, btn_down, btn_up};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         logic          sync1_q;
         logic          sync2_q;
         logic          lvl_q;
         logic [CW-1:0] cnt_q;

         always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               lvl_q   <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= raw[gi];
               sync2_q <= sync1_q;
               // Any agreeing sample restarts the run of differing samples.
               if (sync2_q == lvl_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  lvl_q <= ~lvl_q;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         end

         assign held_w[gi] = lvl_q;
      end
   endgenerate

   always_comb begin
      arb_dir = 2'd3;
      if (held_w[0])      arb_dir = 2'd0;
      else if (held_w[1]) arb_dir = 2'd1;
      else if (held_w[2]) arb_dir = 2'd2;
   end

`ifdef AUTO_REPEAT_EN
   // The acceptance cycle counts as the first timer cycle, so the pulse spacing equals the parameter.
   localparam logic [25:0] DELAY_LOAD  = 26'(REPEAT_DELAY - 1);
   localparam logic [25:0] PERIOD_LOAD = 26'(REPEAT_PERIOD - 1);
   logic [25:0] timer_q;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         move_valid_q <= 1'b0;
         move_dir_q   <= 2'd0;
         held_prev_q  <= 4'd0;
`ifdef AUTO_REPEAT_EN
         timer_q      <= 26'd0;
`endif
      end else begin
         held_prev_q <= held_w;
         case (state_q)
            IDLE: begin
               if (|(held_w & ~held_prev_q)) begin
                  move_dir_q   <= arb_dir;
                  move_valid_q <= 1'b1;
                  state_q      <= REQ;
               end
            end
            REQ, REPEAT: begin
               // REPEAT is a pending auto-repeat request; it differs from REQ only in the reload value.
               if (move_ready) begin
                  move_valid_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
                  timer_q      <= (state_q == REQ) ? DELAY_LOAD : PERIOD_LOAD;
                  state_q      <= DELAY;
`else
                  state_q      <= RELEASE;
`endif
               end
            end
`ifdef AUTO_REPEAT_EN
            DELAY: begin
               if (!held_w[move_dir_q]) begin
                  state_q <= RELEASE;
               end else if (timer_q <= 26'd1) begin
                  move_valid_q <= 1'b1;
                  state_q      <= REPEAT;
               end else begin
                  timer_q <= timer_q - 26'd1;
               end
            end
`endif
            RELEASE: begin
               if (held_w == 4'd0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign move_valid = move_valid_q;
   assign move_dir   = move_dir_q;
   assign held       = held_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat timings; repeat checks follow AUTO_REPEAT_EN.
module tb_input_conditioner;
   localparam int N  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       up    = 1'b0;
   logic       down  = 1'b0;
   logic       left  = 1'b0;
   logic       right = 1'b0;
   logic       ready = 1'b0;
   logic       valid;
   logic [1:0] dir;
   logic [3:0] held;

   int n_cmp = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   input_conditioner #(
      .DEBOUNCE_CYCLES(N),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .CLOCK_50(clk),
      .reset(rst),
      .btn_up(up),
      .btn_down(down),
      .btn_left(left),
      .btn_right(right),
      .move_ready(ready),
      .move_valid(valid),
      .move_dir(dir),
      .held(held)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; ready = 1'b1;
      repeat (20) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_cmp++; if (dir !== 2'd0) begin n_err++; $display("FAIL reset_dir: got %0d want 0", dir); end
      n_cmp++; if (held !== 4'd0) begin n_err++; $display("FAIL reset_held: got %b want 0000", held); end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) step();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b want 0", valid); end
      $display("test_reset done");
   endtask

   task automatic test_glitch();
      @(negedge clk);
      up = 1'b1; ready = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         step();
         n_cmp++; if (held !== 4'd0) begin n_err++; $display("FAIL glitch_held c=%0d: got %b want 0000", c, held); end
         n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid c=%0d: got %b want 0", c, valid); end
         if (c == 3) begin @(negedge clk); up = 1'b0; end
      end
      settle();
      $display("test_glitch done");
   endtask

   task automatic test_single_press();
      logic exp;
      @(negedge clk);
      left = 1'b1; ready = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         step();
         exp = (c == 7);
`ifdef AUTO_REPEAT_EN
         exp = exp || (c == 27) || (c == 35) || (c == 43);
`endif
         n_cmp++; if (valid !== exp) begin n_err++; $display("FAIL left_valid c=%0d: got %b want %b", c, valid, exp); end
         if (exp) begin
            n_cmp++; if (dir !== 2'd2) begin n_err++; $display("FAIL left_dir c=%0d: got %0d want 2", c, dir); end
         end
         if (c == 12) begin
            n_cmp++; if (held !== 4'b0100) begin n_err++; $display("FAIL left_held: got %b want 0100", held); end
         end
         if (c == 44) begin @(negedge clk); left = 1'b0; end
      end
      settle();
      $display("test_single_press done");
   endtask

   task automatic test_priority();
      logic exp;
      @(negedge clk);
      up = 1'b1; right = 1'b1; ready = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         step();
         exp = (c == 7);
         n_cmp++; if (valid !== exp) begin n_err++; $display("FAIL prio_valid c=%0d: got %b want %b", c, valid, exp); end
         if (exp) begin
            n_cmp++; if (dir !== 2'd0) begin n_err++; $display("FAIL prio_dir: got %0d want 0", dir); end
         end
         if (c == 12) begin
            n_cmp++; if (held !== 4'b1001) begin n_err++; $display("FAIL prio_held_both: got %b want 1001", held); end
         end
         if (c == 25) begin
            n_cmp++; if (held !== 4'b1000) begin n_err++; $display("FAIL prio_held_right: got %b want 1000", held); end
         end
         if (c == 10) begin @(negedge clk); up = 1'b0; end
         if (c == 35) begin @(negedge clk); right = 1'b0; end
      end
      settle();
      $display("test_priority done");
   endtask

   task automatic test_backpressure();
      logic exp;
      @(negedge clk);
      down = 1'b1; ready = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         step();
         exp = (c >= 7) && (c <= 50);
         n_cmp++; if (valid !== exp) begin n_err++; $display("FAIL bp_valid c=%0d: got %b want %b", c, valid, exp); end
         if (exp) begin
            n_cmp++; if (dir !== 2'd1) begin n_err++; $display("FAIL bp_dir c=%0d: got %0d want 1", c, dir); end
         end
         if (c == 20) begin
            n_cmp++; if (held !== 4'd0) begin n_err++; $display("FAIL bp_held: got %b want 0000", held); end
         end
         if (c == 10) begin @(negedge clk); down = 1'b0; end
         if (c == 50) begin @(negedge clk); ready = 1'b1; end
      end
      settle();
      $display("test_backpressure done");
   endtask

   task automatic test_reset_mid_request();
      logic exp;
      @(negedge clk);
      left = 1'b1; ready = 1'b0;
      repeat (8) step();
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid: got %b want 1", valid); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", valid); end
      n_cmp++; if (held !== 4'd0) begin n_err++; $display("FAIL rmid_held: got %b want 0000", held); end
      n_cmp++; if (dir !== 2'd0) begin n_err++; $display("FAIL rmid_dir: got %0d want 0", dir); end
      step();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step();
         exp = (c >= 7);
         n_cmp++; if (valid !== exp) begin n_err++; $display("FAIL rmid_reissue c=%0d: got %b want %b", c, valid, exp); end
         if (exp) begin
            n_cmp++; if (dir !== 2'd2) begin n_err++; $display("FAIL rmid_reissue_dir c=%0d: got %0d want 2", c, dir); end
         end
      end
      settle();
      $display("test_reset_mid_request done");
   endtask

`ifndef AUTO_REPEAT_EN
   task automatic test_one_shot();
      int pulses;
      int first;
      pulses = 0;
      first  = 0;
      @(negedge clk);
      right = 1'b1; ready = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         step();
         if (valid === 1'b1) begin
            pulses++;
            if (pulses == 1) first = c;
            n_cmp++; if (dir !== 2'd3) begin n_err++; $display("FAIL oneshot_dir c=%0d: got %0d want 3", c, dir); end
         end
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL oneshot_count: got %0d want 1", pulses); end
      n_cmp++; if (first !== 7) begin n_err++; $display("FAIL oneshot_latency: got %0d want 7", first); end
      settle();
      $display("test_one_shot done");
   endtask
`endif

   initial begin
      test_reset();
      test_glitch();
      test_single_press();
      test_priority();
      test_backpressure();
      test_reset_mid_request();
`ifndef AUTO_REPEAT_EN
      test_one_shot();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-sample count before a debounced level changes (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the cycles from first-move acceptance to the first auto-repeat (0.5 s).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 5000000, giving the cycles between subsequent auto-repeats (0.1 s).
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the 50 MHz system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports btn_up, btn_down, btn_left and btn_right, each input, 1 bit: raw asynchronous button levels, 1 = pressed.
REQ-007 The block SHALL have port move_ready, input, 1 bit: the consumer accepts the current move request.
REQ-008 The block SHALL have port move_valid, output, 1 bit: a move request is pending.
REQ-009 The block SHALL have port move_dir, output, 2 bits, encoded 0 = up, 1 = down, 2 = left, 3 = right.
REQ-010 The block SHALL have port held, output, 4 bits: debounced levels, bit order {right, left, down, up}.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer clocked by CLOCK_50.
REQ-012 Each button SHALL have its own debounce counter; it resets whenever the synchronized value equals the debounced value.
REQ-013 The debounced value SHALL toggle on the cycle the counter reaches DEBOUNCE_CYCLES consecutive differing samples, and the counter SHALL then clear.
REQ-014 Request latency SHALL be DEBOUNCE_CYCLES+3 cycles from the first raw-high sample to move_valid high (2 sync + N debounce + 1 register).
REQ-015 Direction arbitration SHALL use fixed priority up > down > left > right over the debounced levels.
REQ-016 The block SHALL implement an FSM with states IDLE, REQ, DELAY, REPEAT and RELEASE.
REQ-017 In IDLE, a rising edge of any debounced level SHALL latch the arbitrated direction, set move_valid and enter REQ.
REQ-018 In REQ, move_valid and move_dir SHALL hold stable until a cycle where move_valid and move_ready are both 1; a request is never withdrawn by button release.
REQ-019 On acceptance in REQ, the FSM SHALL enter DELAY and load the repeat timer with REPEAT_DELAY if this was a first move, or REPEAT_PERIOD if it was a repeat.
REQ-020 In DELAY, release of the latched button SHALL cause a transition to RELEASE.
REQ-021 In DELAY, timer expiry with the latched button still held SHALL set move_valid and enter REQ as a repeat.
REQ-022 In RELEASE, the FSM SHALL wait until all held bits are 0, then go to IDLE; this requires a full release before the next direction is issued.
REQ-023 New presses while in REQ or DELAY SHALL be ignored; no request queueing, at most one outstanding request.
REQ-024 A press and an acceptance in the same cycle SHALL complete the acceptance only; the press is not issued.
REQ-025 The timer SHALL be 26 bits and saturate at 0, with no wrap-around.
REQ-026 move_ready SHALL be ignored while move_valid is 0.

Reset
REQ-027 Asserting reset SHALL immediately clear synchronizers, debounce counters, held, move_valid, move_dir (to 0), the timer and the FSM (to IDLE), including mid-request.
REQ-028 A button held through reset deassertion SHALL be treated as a new press after debounce.

Configuration
REQ-029 The macro AUTO_REPEAT_EN SHALL control auto-repeat; when defined, the REQ/DELAY repeat behaviour above applies.
REQ-030 When AUTO_REPEAT_EN is undefined, acceptance SHALL go directly to RELEASE, the timer SHALL be removed, and exactly one move is issued per press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-031 A 3-cycle glitch on btn_up -> held stays 0 and move_valid never rises.
REQ-032 btn_left held with move_ready tied 1 -> move_valid pulses 1 cycle at cycle 7 with move_dir=2; with AUTO_REPEAT_EN, the next pulses are 20 cycles later, then every 8 cycles.
REQ-033 btn_up and btn_right pressed in the same cycle -> move_dir=0; after btn_up is released and btn_right stays held, no new request is issued until a full release.
REQ-034 move_ready=0 for 50 cycles while btn_down is released at cycle 10 -> move_valid stays 1 with move_dir=1 until move_ready=1, then 0 with no repeat.
REQ-035 reset pulsed while move_valid=1 -> move_valid=0 and held=0 that cycle; the still-held button re-issues at cycle 7 after reset release.
REQ-036 With AUTO_REPEAT_EN undefined, btn_right held for 200 cycles -> exactly one request with move_dir=3.
